// File: rtl/isqrt_seq.sv
// Sequential non-restoring integer square root, ITER_PER_CLK result bits per clock,
// valid/ready on both sides. Define ISQRT_REM_EN to add the corrected remainder port.
module isqrt_seq #(
    parameter  int IN_W         = 32,
    parameter  int ITER_PER_CLK = 1,
    localparam int OUT_W        = IN_W / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] root,
    output logic             busy
`ifdef ISQRT_REM_EN
    ,
    output logic [OUT_W:0]   rem
`endif
);

    localparam int RW    = OUT_W + 2;
    localparam int STEPS = OUT_W / ITER_PER_CLK;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [IN_W-1:0]   opnd;
    logic [OUT_W-1:0]  q, q_it;
    logic [RW-1:0]     r, r_it;
    logic [RW-1:0]     left, right;
    logic [CW-1:0]     cnt;
    logic              last;

    assign last = (cnt == CW'(STEPS - 1));

    // NOTE: combinational chains use blocking '=' and give every variable a default
    // first, so the unrolled iterations see each other's results and no latch appears.
    always_comb begin
        q_it  = q;
        r_it  = r;
        left  = '0;
        right = '0;
        for (int i = 0; i < ITER_PER_CLK; i++) begin
            left  = {r_it[RW-3:0], opnd[IN_W-1-2*i -: 2]};
            right = {q_it, r_it[RW-1], 1'b1};
            if (r_it[RW-1]) r_it = left + right;
            else            r_it = left - right;
            q_it = {q_it[OUT_W-2:0], ~r_it[RW-1]};
        end
    end

`ifdef ISQRT_REM_EN
    // A negative final partial remainder still owes the last trial term 2q+1.
    logic [RW-1:0] r_fix;
    assign r_fix = r_it[RW-1] ? r_it + {1'b0, q_it, 1'b1} : r_it;
`endif

    // NOTE: state registers use non-blocking '<=' so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd <= '0;
            q    <= '0;
            r    <= '0;
            cnt  <= '0;
            root <= '0;
`ifdef ISQRT_REM_EN
            rem  <= '0;
`endif
        end else begin
            if (state == IDLE && in_valid) begin
                opnd <= din;
                q    <= '0;
                r    <= '0;
                cnt  <= '0;
            end else if (state == CALC) begin
                opnd <= opnd << (2 * ITER_PER_CLK);
                q    <= q_it;
                r    <= r_it;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    root <= q_it;
`ifdef ISQRT_REM_EN
                    rem  <= r_fix[OUT_W:0];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: directed edge cases plus a randomized
// back-to-back stream scored against a plain-arithmetic square-root model.
module tb_isqrt_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] din;
    logic [15:0] root;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [15:0] din4;
    logic [7:0]  root4;
`ifdef ISQRT_REM_EN
    logic [16:0] rem;
    logic [8:0]  rem4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    isqrt_seq #(.IN_W(32), .ITER_PER_CLK(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .root(root), .busy(busy)
`ifdef ISQRT_REM_EN
        , .rem(rem)
`endif
    );

    isqrt_seq #(.IN_W(16), .ITER_PER_CLK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .din(din4),
        .out_valid(out_valid4), .out_ready(out_ready4), .root(root4), .busy(busy4)
`ifdef ISQRT_REM_EN
        , .rem(rem4)
`endif
    );

    function automatic longint model_root(longint d);
        longint s = longint'($rtoi($sqrt(real'(d))));
        while (s * s > d) s--;
        while ((s + 1) * (s + 1) <= d) s++;
        return s;
    endfunction

    task automatic expect_int(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Presents one operand on the 32-bit DUT and returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] d);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        in_valid = 1'b1;
        din      = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        din      = $urandom;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 0; out_ready = 0; din = '0;
        in_valid4 = 0; out_ready4 = 0; din4 = '0;
        #2;
        expect_int("reset in_ready",  in_ready, 1);
        expect_int("reset out_valid", out_valid, 0);
        expect_int("reset busy",      busy, 0);
        expect_int("reset root",      root, 0);
        expect_int("reset in_ready4", in_ready4, 1);
        expect_int("reset out_valid4", out_valid4, 0);
`ifdef ISQRT_REM_EN
        expect_int("reset rem", rem, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat;
        out_ready = 1'b1;
        issue(32'd1000000);
        expect_int("basic in_ready low in CALC", in_ready, 0);
        expect_int("basic busy in CALC", busy, 1);
        wait_out(lat);
        expect_int("basic latency", lat, 16);
        expect_int("basic root", root, 1000);
`ifdef ISQRT_REM_EN
        expect_int("basic rem", rem, 0);
`endif
        @(posedge clk); #1;
        expect_int("basic out_valid after handshake", out_valid, 0);
        expect_int("basic in_ready after handshake", in_ready, 1);
    endtask

    task automatic test_edges;
        logic [31:0] vals [2] = '{32'd0, 32'hFFFF_FFFF};
        int lat;
        out_ready = 1'b1;
        foreach (vals[k]) begin
            issue(vals[k]);
            wait_out(lat);
            expect_int("edge latency", lat, 16);
            expect_int("edge root", root, model_root(longint'(vals[k])));
`ifdef ISQRT_REM_EN
            expect_int("edge rem", rem, (k == 0) ? 0 : 17'h1FFFE);
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        issue(32'd17);
        wait_out(lat);
        expect_int("bp latency", lat, 16);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            din      = $urandom;
            @(posedge clk); #1;
            expect_int("bp out_valid held", out_valid, 1);
            expect_int("bp in_ready low", in_ready, 0);
            expect_int("bp root held", root, 4);
`ifdef ISQRT_REM_EN
            expect_int("bp rem held", rem, 1);
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        expect_int("bp released out_valid", out_valid, 0);
        expect_int("bp released in_ready", in_ready, 1);
        @(posedge clk); #1;
        expect_int("bp stray in_valid ignored", busy, 0);
    endtask

    task automatic test_abort;
        int lat;
        out_ready = 1'b1;
        issue($urandom);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        expect_int("abort out_valid", out_valid, 0);
        expect_int("abort in_ready", in_ready, 1);
        expect_int("abort busy", busy, 0);
        expect_int("abort root cleared", root, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(32'd81);
        wait_out(lat);
        expect_int("abort next latency", lat, 16);
        expect_int("abort next root", root, 9);
        @(posedge clk); #1;
    endtask

    task automatic test_iter4;
        logic [15:0] d;
        int lat;
        out_ready4 = 1'b1;
        for (int n = 0; n < 12; n++) begin
            d = (n == 0) ? 16'hFFFF : 16'($urandom);
            in_valid4 = 1'b1; din4 = d;
            @(posedge clk); #1;
            in_valid4 = 1'b0; din4 = 16'($urandom);
            lat = 0;
            while (!out_valid4 && lat < 50) begin
                @(posedge clk); #1; lat++;
            end
            expect_int("iter4 latency", lat, 2);
            expect_int("iter4 root", root4, model_root(longint'(d)));
`ifdef ISQRT_REM_EN
            expect_int("iter4 rem", rem4, longint'(d) - model_root(longint'(d)) ** 2);
`endif
            @(posedge clk); #1;
        end
        out_ready4 = 1'b0;
    endtask

    task automatic test_back_to_back;
        longint pend [$];
        longint d, r;
        int sent = 0, got = 0, cycles = 0;
        while (got < 1000 && cycles < 60000) begin
            @(posedge clk); #1;
            in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
            din       = ($urandom_range(3) == 0) ? 32'($urandom_range(300)) : $urandom;
            out_ready = ($urandom_range(2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                pend.push_back(longint'(din));
                sent++;
            end
            if (out_valid && out_ready) begin
                got++;
                if (pend.size() == 0) begin
                    expect_int("b2b unexpected result", 1, 0);
                end else begin
                    d = pend.pop_front();
                    r = longint'(root);
                    expect_int("b2b root vs model", r, model_root(d));
                    expect_int("b2b root bracket", (r * r <= d) && (d < (r + 1) * (r + 1)), 1);
`ifdef ISQRT_REM_EN
                    expect_int("b2b rem", rem, d - r * r);
`endif
                end
            end
            cycles++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        expect_int("b2b results received", got, 1000);
        expect_int("b2b operands outstanding", pend.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        expect_int("b2b idle at end", busy, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_backpressure();
        test_abort();
        test_iter4();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
